// File: rtl/seg_scan_display.sv
// seg_scan_display
//   Binary-to-BCD seven-segment driver for a common-anode multi-digit display.
//   A loaded value is converted by a sequential double-dabble engine (one bit
//   per clock). The result is then time-multiplexed onto the digits, with
//   optional leading-zero blanking, per-digit decimal points and an
//   overflow indication.
//
// Parameters
//   NUM_DIGITS : digits scanned (1..8)
//   VAL_W      : width of the binary input value
//   DIV_CNT    : clk cycles each digit stays lit (>= 2)
//
// Ports
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   value    : unsigned binary value, captured on load
//   load     : one-cycle strobe, ignored while busy
//   blank_lz : 1 = blank leading zeros (digit 0 is never blanked)
//   dp_mask  : bit i lights the decimal point of digit i (sampled live)
//   busy     : conversion in progress
//   ovf      : last loaded value did not fit in NUM_DIGITS decimal digits
//   an       : anode enables, active low, one-hot-low
//   seg      : segments {g,f,e,d,c,b,a}, active low
//   dp       : decimal point, active low
module seg_scan_display #(
    parameter int NUM_DIGITS = 4,
    parameter int VAL_W      = 14,
    parameter int DIV_CNT    = 26244
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [VAL_W-1:0]      value,
    input  logic                  load,
    input  logic                  blank_lz,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    output logic                  busy,
    output logic                  ovf,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int BCD_W  = 4 * NUM_DIGITS;
    localparam int SCR_W  = BCD_W + 4;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIV_W  = $clog2(DIV_CNT);
    localparam int ITER_W = $clog2(VAL_W + 1);

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t state_q, state_d;

    logic [VAL_W-1:0]  bin_q;
    logic [SCR_W-1:0]  scr_q;
    logic [SCR_W-1:0]  scr_adj;
    logic [SCR_W-1:0]  scr_next;
    logic              sticky_q;
    logic              sticky_next;
    logic [ITER_W-1:0] iter_q;
    logic [BCD_W-1:0]  disp_q;
    logic              start;
    logic              last_iter;

    // ---------------------------------------------------------------
    // Conversion FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        last_iter = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = CONV;
                    start   = 1'b1;
                end
            end
            CONV: begin
                if (iter_q == ITER_W'(1)) begin
                    state_d   = IDLE;
                    last_iter = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == CONV);

    // ---------------------------------------------------------------
    // Double-dabble step: add 3 to every nibble >= 5, then shift in the
    // next binary bit. The scratch carries one nibble beyond the display;
    // any bit pushed out of that extra nibble is caught by a sticky flag,
    // so overflow is detected even when the value exceeds the extra
    // nibble's decade as well.
    // ---------------------------------------------------------------
    always_comb begin
        scr_adj = scr_q;
        for (int unsigned n = 0; n < NUM_DIGITS + 1; n++) begin
            if (scr_q[4*n +: 4] >= 4'd5) begin
                scr_adj[4*n +: 4] = scr_q[4*n +: 4] + 4'd3;
            end
        end
        scr_next    = {scr_adj[SCR_W-2:0], bin_q[VAL_W-1]};
        sticky_next = sticky_q | scr_adj[SCR_W-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q    <= '0;
            scr_q    <= '0;
            sticky_q <= 1'b0;
            iter_q   <= '0;
            disp_q   <= '0;
            ovf      <= 1'b0;
        end else if (start) begin
            bin_q    <= value;
            scr_q    <= '0;
            sticky_q <= 1'b0;
            iter_q   <= ITER_W'(VAL_W);
        end else if (state_q == CONV) begin
            bin_q    <= bin_q << 1;
            scr_q    <= scr_next;
            sticky_q <= sticky_next;
            iter_q   <= iter_q - ITER_W'(1);
            // Display only changes once the full result is ready.
            if (last_iter) begin
                disp_q <= scr_next[BCD_W-1:0];
                ovf    <= sticky_next | (scr_next[SCR_W-1 -: 4] != 4'd0);
            end
        end
    end

    // ---------------------------------------------------------------
    // Scan divider and digit index
    // ---------------------------------------------------------------
    logic [DIV_W-1:0]      div_q;
    logic [IDX_W-1:0]      idx_q;
    logic [IDX_W-1:0]      idx_next;
    logic                  wrap;
    logic [NUM_DIGITS-1:0] blank;
    logic                  zero_run;
    logic [3:0]            cur_digit;
    logic [6:0]            seg_next;
    logic                  dp_next;

    assign wrap     = (div_q == DIV_W'(DIV_CNT - 1));
    assign idx_next = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);

    function automatic logic [6:0] dec7(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Walk from the most significant digit down; a digit is blankable
    // while it and everything above it is zero. Digit 0 always shows.
    always_comb begin
        blank    = '0;
        zero_run = 1'b1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            zero_run = zero_run & (disp_q[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
            blank[NUM_DIGITS-1-k] = zero_run & blank_lz & (k != NUM_DIGITS - 1);
        end
    end

    always_comb begin
        cur_digit = disp_q[{idx_next, 2'b00} +: 4];
        seg_next  = dec7(cur_digit);
        dp_next   = ~dp_mask[idx_next];
        if (ovf) begin
            seg_next = 7'h3F;
            dp_next  = 1'b1;
        end else if (blank[idx_next]) begin
            seg_next = 7'h7F;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            idx_q <= '0;
            an    <= '1;
            seg   <= 7'h7F;
            dp    <= 1'b1;
        end else if (wrap) begin
            div_q <= '0;
            idx_q <= idx_next;
            an    <= ~(NUM_DIGITS'(1) << idx_next);
            seg   <= seg_next;
            dp    <= dp_next;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
module tb_seg_scan_display;

    localparam int VAL_W = 14;
    localparam int DIV   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [VAL_W-1:0]  value;
    logic              load;
    logic              blank_lz;
    logic [7:0]        mask8;

    logic [3:0] dpm4;
    logic [5:0] dpm6;
    logic [0:0] dpm1;
    assign dpm4 = mask8[3:0];
    assign dpm6 = mask8[5:0];
    assign dpm1 = mask8[0:0];

    logic       busy4, ovf4, dp4;
    logic [3:0] an4;
    logic [6:0] seg4;
    logic       busy6, ovf6, dp6;
    logic [5:0] an6;
    logic [6:0] seg6;
    logic       busy1, ovf1, dp1;
    logic [0:0] an1;
    logic [6:0] seg1;

    seg_scan_display #(.NUM_DIGITS(4), .VAL_W(VAL_W), .DIV_CNT(DIV)) dut4 (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load), .blank_lz(blank_lz),
        .dp_mask(dpm4), .busy(busy4), .ovf(ovf4), .an(an4), .seg(seg4), .dp(dp4));

    seg_scan_display #(.NUM_DIGITS(6), .VAL_W(VAL_W), .DIV_CNT(DIV)) dut6 (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load), .blank_lz(blank_lz),
        .dp_mask(dpm6), .busy(busy6), .ovf(ovf6), .an(an6), .seg(seg6), .dp(dp6));

    seg_scan_display #(.NUM_DIGITS(1), .VAL_W(VAL_W), .DIV_CNT(DIV)) dut1 (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load), .blank_lz(blank_lz),
        .dp_mask(dpm1), .busy(busy1), .ovf(ovf1), .an(an1), .seg(seg1), .dp(dp1));

    int n_cmp = 0;
    int n_bad = 0;

    // Scan-output view of the selected instance (0: 4 digits, 1: 6, 2: 1).
    int         sel = 0;
    logic [7:0] an_m;
    logic [6:0] seg_m;
    logic       dp_m;
    always_comb begin
        an_m  = {4'hF, an4};
        seg_m = seg4;
        dp_m  = dp4;
        if (sel == 1) begin
            an_m  = {2'b11, an6};
            seg_m = seg6;
            dp_m  = dp6;
        end else if (sel == 2) begin
            an_m  = {7'h7F, an1};
            seg_m = seg1;
            dp_m  = dp1;
        end
    end

    typedef struct {
        int          id;
        logic        ovf;
        logic [31:0] bcd;
    } conv_t;

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } scan_t;

    conv_t conv_q[$];
    scan_t scan_q[$];

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [31:0] bcd_of(input int v, input int n);
        logic [31:0] r = '0;
        int x = v;
        for (int i = 0; i < n; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] dec7(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] seg_model(input int v, input int n, input int i, input logic blz);
        if (v >= pow10(n)) return 7'h3F;
        if (blz && i > 0 && v < pow10(i)) return 7'h7F;
        return dec7((v / pow10(i)) % 10);
    endfunction

    function automatic int ndig(input int s);
        return (s == 0) ? 4 : (s == 1) ? 6 : 1;
    endfunction

    task automatic push_conv(input int v);
        conv_t e;
        for (int id = 0; id < 3; id++) begin
            e.id  = id;
            e.ovf = (v >= pow10(ndig(id)));
            e.bcd = bcd_of(v, ndig(id));
            conv_q.push_back(e);
        end
    endtask

    task automatic push_scan(input int v, input int n, input logic blz, input logic [7:0] m);
        scan_t e;
        for (int i = 0; i < n; i++) begin
            e.an  = 8'hFF ^ (8'h01 << i);
            e.seg = seg_model(v, n, i, blz);
            e.dp  = (v >= pow10(n)) ? 1'b1 : ~m[i];
            scan_q.push_back(e);
        end
    endtask

    // Loads a value into all instances, counts busy cycles and optionally
    // fires a second load while the conversion is still running.
    task automatic do_load(input int v, input int re_at, input int re_val);
        int cnt = 0;
        @(negedge clk);
        value = VAL_W'(v);
        load  = 1'b1;
        push_conv(v);
        @(negedge clk);
        load = 1'b0;
        while (busy4 === 1'b1 && cnt < VAL_W + 8) begin
            cnt++;
            if (cnt == re_at) begin
                value = VAL_W'(re_val);
                load  = 1'b1;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
        n_cmp++;
        if (cnt !== VAL_W) begin
            n_bad++;
            $display("FAIL busy_len v=%0d: got %0d cycles, expected %0d", v, cnt, VAL_W);
        end
    endtask

    task automatic check_conv;
        conv_t       e;
        logic        a_ovf;
        logic [31:0] a_bcd;
        while (conv_q.size() > 0) begin
            e = conv_q.pop_front();
            case (e.id)
                0:       begin a_ovf = ovf4; a_bcd = 32'(dut4.disp_q); end
                1:       begin a_ovf = ovf6; a_bcd = 32'(dut6.disp_q); end
                default: begin a_ovf = ovf1; a_bcd = 32'(dut1.disp_q); end
            endcase
            n_cmp++;
            if (a_ovf !== e.ovf) begin
                n_bad++;
                $display("FAIL conv_ovf n=%0d: got %b, expected %b", ndig(e.id), a_ovf, e.ovf);
            end
            if (!e.ovf) begin
                n_cmp++;
                if (a_bcd !== e.bcd) begin
                    n_bad++;
                    $display("FAIL conv_bcd n=%0d: got %h, expected %h", ndig(e.id), a_bcd, e.bcd);
                end
            end
        end
    endtask

    // Syncs to digit 0 becoming lit, then checks one full scan frame.
    task automatic check_frame;
        int         n = ndig(sel);
        int         lim = (n + 1) * DIV + 4;
        logic [7:0] prev;
        bit         found = 1'b0;
        scan_t      e;
        if (n == 1) begin
            repeat (DIV + 1) @(negedge clk);
            found = 1'b1;
        end else begin
            prev = an_m;
            for (int k = 0; k < lim && !found; k++) begin
                @(negedge clk);
                if (an_m != prev && an_m == 8'hFE) found = 1'b1;
                prev = an_m;
            end
        end
        if (!found) begin
            n_cmp++;
            n_bad++;
            $display("FAIL frame_sync sel=%0d: got an=%b, expected digit 0 within %0d cycles", sel, an_m, lim);
            scan_q.delete();
            return;
        end
        for (int i = 0; i < n; i++) begin
            if (scan_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL frame_queue sel=%0d: got empty queue, expected %0d entries", sel, n - i);
                return;
            end
            e = scan_q.pop_front();
            n_cmp++;
            if ({an_m, seg_m, dp_m} !== {e.an, e.seg, e.dp}) begin
                n_bad++;
                $display("FAIL frame_digit sel=%0d i=%0d: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                         sel, i, an_m, seg_m, dp_m, e.an, e.seg, e.dp);
            end
            repeat (DIV - 1) @(negedge clk);
            n_cmp++;
            if (an_m !== e.an) begin
                n_bad++;
                $display("FAIL frame_hold sel=%0d i=%0d: got an=%b, expected an=%b", sel, i, an_m, e.an);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        load     = 1'b0;
        value    = '0;
        blank_lz = 1'b0;
        mask8    = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy4, ovf4, an4, seg4, dp4} !== {1'b0, 1'b0, 4'hF, 7'h7F, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_out: got busy=%b ovf=%b an=%b seg=%h dp=%b, expected 0 0 1111 7f 1",
                     busy4, ovf4, an4, seg4, dp4);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (an4 !== 4'hF) begin
            n_bad++;
            $display("FAIL reset_dark: got an=%b, expected 1111", an4);
        end
        @(negedge clk);
        n_cmp++;
        if ({an4, seg4, dp4} !== {4'b1101, 7'h40, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_first: got an=%b seg=%h dp=%b, expected 1101 40 1", an4, seg4, dp4);
        end
    endtask

    task automatic test_scan_zero;
        sel = 0;
        blank_lz = 1'b0;
        push_scan(0, 4, 1'b0, mask8);
        check_frame();
        blank_lz = 1'b1;
        push_scan(0, 4, 1'b1, mask8);
        check_frame();
        blank_lz = 1'b0;
    endtask

    task automatic test_1234;
        do_load(1234, 0, 0);
        check_conv();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            push_scan(1234, ndig(s), blank_lz, mask8);
            check_frame();
        end
        sel = 0;
    endtask

    task automatic test_ovf;
        mask8 = 8'hFF;
        do_load(10000, 0, 0);
        check_conv();
        for (int s = 0; s < 2; s++) begin
            sel = s;
            push_scan(10000, ndig(s), blank_lz, mask8);
            check_frame();
        end
        sel = 0;
        mask8 = 8'h00;
        do_load(9999, 0, 0);
        check_conv();
        push_scan(9999, 4, blank_lz, mask8);
        check_frame();
    endtask

    task automatic test_blank_dp;
        blank_lz = 1'b1;
        mask8    = 8'b0000_0010;
        do_load(7, 0, 0);
        check_conv();
        for (int s = 0; s < 2; s++) begin
            sel = s;
            push_scan(7, ndig(s), 1'b1, mask8);
            check_frame();
        end
        sel      = 0;
        blank_lz = 1'b0;
        mask8    = '0;
    endtask

    task automatic test_back_to_back;
        do_load(42, 5, 99);
        check_conv();
        push_scan(42, 4, blank_lz, mask8);
        check_frame();
        // second load lands on the final conversion edge
        do_load(55, VAL_W, 77);
        @(negedge clk);
        n_cmp++;
        if (busy4 !== 1'b0) begin
            n_bad++;
            $display("FAIL final_edge_load: got busy=%b, expected 0", busy4);
        end
        check_conv();
    endtask

    task automatic test_reset_mid;
        do_load(10000, 0, 0);
        check_conv();
        @(negedge clk);
        value = VAL_W'(300);
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy4, ovf4, an4, seg4, dp4} !== {1'b0, 1'b0, 4'hF, 7'h7F, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_mid_out: got busy=%b ovf=%b an=%b seg=%h dp=%b, expected 0 0 1111 7f 1",
                     busy4, ovf4, an4, seg4, dp4);
        end
        n_cmp++;
        if (dut4.disp_q !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_mid_disp: got %h, expected 0000", dut4.disp_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
        push_scan(0, 4, blank_lz, mask8);
        check_frame();
    endtask

    task automatic test_sweep;
        int vals[$];
        for (int v = 0; v <= 40; v++) vals.push_back(v);
        for (int v = 995; v <= 1005; v++) vals.push_back(v);
        for (int v = 9990; v <= 10010; v++) vals.push_back(v);
        for (int v = 16370; v <= 16383; v++) vals.push_back(v);
        for (int k = 0; k < 60; k++) vals.push_back(int'($urandom_range(16383, 0)));
        foreach (vals[j]) begin
            do_load(vals[j], 0, 0);
            check_conv();
        end
    endtask

    initial begin
        test_reset();
        test_scan_zero();
        test_1234();
        test_ovf();
        test_blank_dp();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
